// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converters.
// Holds the FSM encoding, the shift count and the digit-correction constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Three BCD digits convert to a 10-bit binary value in ten shift steps.
  localparam int unsigned DIGITS      = 3;
  localparam int unsigned BCD_W       = 4 * DIGITS;
  localparam int unsigned BIN_W       = 10;
  localparam int unsigned SHIFT_COUNT = 10;
  localparam int unsigned CNT_W       = 4;

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SHIFT_COUNT - 1);

  // BCD -> binary: a digit that is >= 8 after a right shift has 3 removed.
  localparam logic [3:0] UNDABBLE_THRESH = 4'd8;
  localparam logic [3:0] UNDABBLE_OFFSET = 4'd3;

  // Binary -> BCD: a digit that is >= 5 before a left shift has 3 added.
  localparam logic [3:0] DABBLE_THRESH = 4'd5;
  localparam logic [3:0] DABBLE_OFFSET = 4'd3;

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Request/result bundle between a requester and the BCD-to-binary converter.
interface bcd_to_binary_if;

  logic       start;
  logic [3:0] h;
  logic [3:0] t;
  logic [3:0] o;
  logic       busy;
  logic       done;
  logic [7:0] bin;
  logic       ovf;
  logic       err;

  modport master (
    output start, h, t, o,
    input  busy, done, bin, ovf, err
  );

  modport slave (
    input  start, h, t, o,
    output busy, done, bin, ovf, err
  );

endinterface

// File: rtl/bcd_to_binary_undabble.sv
// One-digit correction step of the reverse double-dabble: digits >= 8 lose 3.
module undabble
  import bcd_pkg::*;
(
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  assign d_out = (d_in >= UNDABBLE_THRESH) ? (d_in - UNDABBLE_OFFSET) : d_in;

endmodule

// File: rtl/bcd_to_binary.sv
// Three-digit BCD to 8-bit binary converter using a serial reverse double-dabble.
// One conversion takes ten shift cycles; invalid digits short-circuit to DONE with err.
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int SAT = 0
) (
  input logic           clk,
  input logic           rst,
  bcd_to_binary_if.slave bus
);

  localparam int SHREG_W = BCD_W + BIN_W;

  bcd_state_t         state_q, state_d;
  logic [SHREG_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [7:0]         bin_q,   bin_d;
  logic               ovf_q,   ovf_d;
  logic               err_q,   err_d;

  logic               digits_ok;
  logic [SHREG_W-1:0] shifted;
  logic [BCD_W-1:0]   corrected;
  logic [BIN_W-1:0]   result;
  logic               result_ovf;

  assign digits_ok = is_bcd_digit(bus.h) && is_bcd_digit(bus.t) && is_bcd_digit(bus.o);

  // The BCD LSB falls into the binary MSB; each digit is then corrected.
  assign shifted = {1'b0, shreg_q[SHREG_W-1:1]};
  assign result  = shifted[BIN_W-1:0];
  assign result_ovf = result > BIN_W'(255);

  undabble u_undabble_o (.d_in(shifted[BIN_W+3:BIN_W]),    .d_out(corrected[3:0]));
  undabble u_undabble_t (.d_in(shifted[BIN_W+7:BIN_W+4]),  .d_out(corrected[7:4]));
  undabble u_undabble_h (.d_in(shifted[BIN_W+11:BIN_W+8]), .d_out(corrected[11:8]));

  // NOTE: every register, datapath included, is cleared by the async reset so an
  // aborted conversion leaves no stale result visible on bin/ovf/err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = digits_ok ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt_q == LAST_SHIFT) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d = '0;
          ovf_d = 1'b0;
          err_d = !digits_ok;
          if (digits_ok) begin
            shreg_d = {bus.h, bus.t, bus.o, {BIN_W{1'b0}}};
            cnt_d   = '0;
          end
        end
      end
      SHIFT: begin
        shreg_d = {corrected, result};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_SHIFT) begin
          ovf_d = result_ovf;
          bin_d = (SAT != 0 && result_ovf) ? 8'hFF : result[7:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == SHIFT);
    bus.done = (state_q == DONE);
  end

  assign bus.bin = bin_q;
  assign bus.ovf = ovf_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: wrapping and saturating instances run in lockstep.
module tb_bcd_to_binary;

  typedef struct {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic [7:0] bin_wrap;
    logic [7:0] bin_sat;
    logic       ovf;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_to_binary_if bus0 ();
  bcd_to_binary_if bus1 ();

  bcd_to_binary #(.SAT(0)) u_dut     (.clk(clk), .rst(rst), .bus(bus0));
  bcd_to_binary #(.SAT(1)) u_dut_sat (.clk(clk), .rst(rst), .bus(bus1));

  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                       input logic start);
    bus0.h = h; bus0.t = t; bus0.o = o; bus0.start = start;
    bus1.h = h; bus1.t = t; bus1.o = o; bus1.start = start;
  endtask

  // Independent arithmetic model for the randomly generated vectors.
  function automatic vec_t model(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    vec_t v;
    int   val;
    v.h = h; v.t = t; v.o = o;
    v.err = (h > 9) || (t > 9) || (o > 9);
    val   = int'(h) * 100 + int'(t) * 10 + int'(o);
    if (v.err) begin
      v.ovf = 1'b0; v.bin_wrap = 8'h00; v.bin_sat = 8'h00;
    end else begin
      v.ovf      = val > 255;
      v.bin_wrap = 8'(val);
      v.bin_sat  = v.ovf ? 8'hFF : 8'(val);
    end
    return v;
  endfunction

  // Scoreboard: each done pulse retires the oldest expected result.
  always @(negedge clk) begin : monitor
    vec_t e;
    if (!rst && bus0.done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {7'd0, bus0.done}, 8'd0);
      end else begin
        e = exp_q.pop_front();
        check("bin_wrap", bus0.bin, e.bin_wrap);
        check("bin_sat",  bus1.bin, e.bin_sat);
        check("ovf",      {7'd0, bus0.ovf}, {7'd0, e.ovf});
        check("err",      {7'd0, bus0.err}, {7'd0, e.err});
        check("sat_done", {7'd0, bus1.done}, 8'd1);
      end
    end
  end

  task automatic run_conv(input vec_t v, input bit disturb);
    int lat;
    int busy_cnt;
    @(negedge clk);
    drive(v.h, v.t, v.o, 1'b1);
    exp_q.push_back(v);
    @(posedge clk);
    #1 drive(~v.h, ~v.t, ~v.o, 1'b0);
    lat      = 0;
    busy_cnt = 0;
    while (1) begin
      @(negedge clk);
      if (bus0.busy) busy_cnt++;
      if (bus0.done) break;
      if (disturb && lat == 3) drive(4'd9, 4'd9, 4'd9, 1'b1);
      else if (disturb && lat == 4) drive(4'd1, 4'd1, 4'd1, 1'b0);
      lat++;
      if (lat > 30) break;
    end
    check("done_latency", 8'(lat), v.err ? 8'd0 : 8'd10);
    check("busy_cycles", 8'(busy_cnt), v.err ? 8'd0 : 8'd10);
    @(negedge clk);
    check("done_width", {7'd0, bus0.done}, 8'd0);
    check("bin_hold",   bus0.bin, v.bin_wrap);
    check("err_hold",   {7'd0, bus0.err}, {7'd0, v.err});
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{4'd2, 4'd5, 4'd5, 8'hFF, 8'hFF, 1'b0, 1'b0};
    tbl[1] = '{4'd1, 4'd2, 4'd8, 8'h80, 8'h80, 1'b0, 1'b0};
    tbl[2] = '{4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{4'd9, 4'd9, 4'd9, 8'hE7, 8'hFF, 1'b1, 1'b0};
    tbl[4] = '{4'd1, 4'd10, 4'd3, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[5] = '{4'd2, 4'd5, 4'd6, 8'h00, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{4'd1, 4'd0, 4'd0, 8'h64, 8'h64, 1'b0, 1'b0};
    tbl[7] = '{4'd0, 4'd9, 4'd9, 8'h63, 8'h63, 1'b0, 1'b0};
    tbl[8] = '{4'd15, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[9] = '{4'd0, 4'd4, 4'd2, 8'h2A, 8'h2A, 1'b0, 1'b0};

    rst = 1'b1;
    drive(4'd0, 4'd0, 4'd0, 1'b0);
    #1;
    check("rst_busy", {7'd0, bus0.busy}, 8'd0);
    check("rst_done", {7'd0, bus0.done}, 8'd0);
    check("rst_bin",  bus0.bin, 8'h00);
    check("rst_ovf",  {7'd0, bus0.ovf}, 8'd0);
    check("rst_err",  {7'd0, bus0.err}, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_conv(tbl[i], 1'b0);

    // err followed by ovf: both flags must clear on the next accepted start.
    run_conv(tbl[4], 1'b0);
    run_conv(tbl[3], 1'b0);
    run_conv(tbl[6], 1'b0);

    // New start and digits during SHIFT are ignored.
    run_conv(tbl[0], 1'b1);

    for (int i = 0; i < 12; i++) begin
      logic [3:0] rh, rt, ro;
      rh = 4'($urandom_range(0, 9));
      rt = 4'($urandom_range(0, 9));
      ro = (i % 4 == 3) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      run_conv(model(rh, rt, ro), 1'b0);
    end

    // Reset five edges into a conversion aborts it with no done pulse.
    @(negedge clk);
    drive(4'd9, 4'd9, 4'd9, 1'b1);
    @(posedge clk);
    #1 drive(4'd0, 4'd0, 4'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", {7'd0, bus0.busy}, 8'd0);
    check("abort_done", {7'd0, bus0.done}, 8'd0);
    check("abort_bin",  bus0.bin, 8'h00);
    check("abort_ovf",  {7'd0, bus0.ovf}, 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_done", {7'd0, bus0.done}, 8'd0);
    end
    run_conv(tbl[9], 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
